// File: rtl/cdc_mcp_tx_ctrl.sv
// Source-side controller for a multi-cycle-path CDC: holds a word stable on DATA_O,
// flips a request toggle, and waits for the synchronized acknowledge toggle.
module cdc_mcp_tx_ctrl #(
  parameter int unsigned WIDTH          = 5,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [WIDTH-1:0] DATA_I,
  input  logic             VALID_I,
  output logic             READY_O,
  output logic [WIDTH-1:0] DATA_O,
  output logic             REQ_TOGGLE_O,
  input  logic             ACK_TOGGLE_I,
  output logic             BUSY_O,
  output logic             TIMEOUT_O,
  input  logic             CLR_TIMEOUT_I
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_seen_q;
  logic                   ack_sync;
  logic                   ack_event;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   req_q, req_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   to_q, to_d;
  logic                   set_to;

  assign ack_sync  = sync_q[SYNC_STAGES-1];
  assign ack_event = ack_sync ^ ack_seen_q;

  // Ack toggle synchronizer and edge detector; an ack seen while idle is simply absorbed.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      sync_q     <= '0;
      ack_seen_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ACK_TOGGLE_I};
      ack_seen_q <= ack_sync;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic; an ack arriving on the timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    req_d   = req_q;
    set_to  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (VALID_I && ready_q) begin
          data_d  = DATA_I;
          req_d   = ~req_q;
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (ack_event) begin
          state_d = ST_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT)) begin
          state_d = ST_TIMEOUT;
          set_to  = 1'b1;
        end
      end
      ST_TIMEOUT: begin
        if (ack_event) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Sticky flag: a new timeout beats a simultaneous clear.
    to_d = to_q;
    if (set_to)             to_d = 1'b1;
    else if (CLR_TIMEOUT_I) to_d = 1'b0;

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  assign READY_O      = ready_q;
  assign BUSY_O       = busy_q;
  assign DATA_O       = data_q;
  assign REQ_TOGGLE_O = req_q;
  assign TIMEOUT_O    = to_q;

endmodule

// File: doc/cdc_mcp_tx_ctrl.md
Name: cdc_mcp_tx_ctrl

Overview:
Source-side controller for a multi-cycle-path clock domain crossing with a full toggle handshake.
- Accepts a data word over a valid/ready interface and holds it stable on DATA_O.
- Flips a request toggle for the destination domain, then waits for the returning acknowledge toggle, which it synchronizes locally.
- Only after the acknowledge does it accept the next word.
- Detects a missing acknowledge with a timeout counter.
- Sits in the source clock domain, in front of the destination-side toggle pulse synchronizer and capture register.

Parameters:
WIDTH, 5, width of the data word crossed.
SYNC_STAGES, 2, flops in the ACK_TOGGLE_I synchronizer chain; legal values >= 2.
TIMEOUT_CYCLES, 255, cycles spent in WAIT_ACK before a timeout is declared; 0 disables the timeout.

Ports:
CLK_I  input  1  source-domain clock.
RST_I  input  1  asynchronous, active-high reset.
DATA_I  input  WIDTH  word to send.
VALID_I  input  1  DATA_I valid.
READY_O  output  1  block can accept a word; transfer occurs when VALID_I && READY_O at a rising edge.
DATA_O  output  WIDTH  held word presented to the destination capture register.
REQ_TOGGLE_O  output  1  request toggle; one level change per word.
ACK_TOGGLE_I  input  1  acknowledge toggle from the destination domain; asynchronous to CLK_I.
BUSY_O  output  1  a word is in flight (WAIT_ACK or TIMEOUT state).
TIMEOUT_O  output  1  sticky timeout flag.
CLR_TIMEOUT_I  input  1  clears TIMEOUT_O.

Behaviour:
- Reset values (asynchronous on RST_I high):
  - State IDLE; READY_O=1, DATA_O=0, REQ_TOGGLE_O=0, BUSY_O=0, TIMEOUT_O=0.
  - Synchronizer chain all 0; ack_seen=0; timeout counter=0.
- Ack detection:
  - ACK_TOGGLE_I passes through SYNC_STAGES flops; ack_sync is the last stage.
  - ack_event = ack_sync != ack_seen. ack_seen <= ack_sync every cycle.
  - Each level change on ACK_TOGGLE_I therefore yields exactly one single-cycle ack_event, SYNC_STAGES cycles later.
- States:
  - IDLE: READY_O=1, BUSY_O=0.
    - On a transfer: DATA_O<=DATA_I, REQ_TOGGLE_O<=~REQ_TOGGLE_O, counter<=0, go to WAIT_ACK.
    - From the next cycle: READY_O=0 and BUSY_O=1.
  - WAIT_ACK: READY_O=0, BUSY_O=1. Counter increments each cycle, saturating.
    - ack_event -> IDLE; READY_O=1 on the following cycle.
    - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 -> TIMEOUT, with TIMEOUT_O<=1.
  - TIMEOUT: READY_O=0, BUSY_O=1. A late ack_event -> IDLE; TIMEOUT_O stays set.
- DATA_O changes only on an accepted transfer. It is stable for the whole of WAIT_ACK/TIMEOUT; this is the multi-cycle-path guarantee.
- Latency: from the ACK_TOGGLE_I edge to READY_O=1 is SYNC_STAGES+1 CLK_I cycles, ±1 for async sampling.
- Back-to-back throughput: at most one word per (request round trip + SYNC_STAGES + 2) cycles.
- Simultaneous events:
  - ack_event in the same cycle the counter reaches its limit: the ack wins, go to IDLE, no timeout.
  - CLR_TIMEOUT_I in the same cycle a timeout is declared: set wins.
- ack_event while in IDLE (spurious, or caused by remote toggle level after reset): absorbed by the ack_seen update; no state change, no flag.
- VALID_I while READY_O=0: ignored. The upstream block holds the word; the block neither drops nor latches it.
- Reset mid-transfer: returns to IDLE immediately and abandons the word. Both ends must be reset together; any residual toggle mismatch is absorbed as a spurious ack.
- REQ_TOGGLE_O and DATA_O are driven directly from flops (no combinational path to the outputs).

Test Plan:
- Single transfer, SYNC_STAGES=2: send DATA_I=5'h15; bench flips ACK_TOGGLE_I 4 cycles after REQ_TOGGLE_O changes.
  -> REQ_TOGGLE_O goes 0->1; DATA_O=5'h15 and stable throughout; READY_O returns to 1 three cycles after the ack edge.
- Back-to-back: VALID_I held high with words 1,2,3; the ack model responds to every request toggle.
  -> DATA_O takes 1,2,3 in order; REQ_TOGGLE_O ends at 1 after three toggles; no word is lost or duplicated.
- Timeout, TIMEOUT_CYCLES=8: send one word with no ack.
  -> TIMEOUT_O=1 eight cycles after acceptance; READY_O stays 0.
  -> A late ack edge returns READY_O=1 with TIMEOUT_O still 1; CLR_TIMEOUT_I pulse clears it.
- Race: timeout limit and ack_event in the same cycle.
  -> state IDLE, TIMEOUT_O=0.
- Spurious ack: ACK_TOGGLE_I flipped while IDLE.
  -> READY_O stays 1, REQ_TOGGLE_O unchanged; the next transfer still waits for its own ack.
- Reset mid-WAIT_ACK: RST_I asserted asynchronously.
  -> all outputs reach reset values without a clock edge; after release, a fresh transfer completes normally.
